svi_unpacked_bank: RTL and testbench
====================================

Name: svi_unpacked_bank

Overview:
- Parametrised register bank that stores a DEPTH-entry unpacked array of WIDTH-bit words inside an interface instance.
- Accepts commands over a valid/ready handshake:
  - broadcast-replicate an input word to every entry;
  - shift a word in;
  - rotate the bank;
  - stream all entries out serially.
- Exposes the whole unpacked array as an output port.
- Sits beside other unpacked-array-through-interface blocks as the sequential, generalised member of that family.

Parameters:
- DEPTH, 8, number of unpacked entries; legal range 2..256.
- WIDTH, 1, bits per entry; legal range 1..64.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_cmd_valid  input  1  command present.
- o_cmd_ready  output  1  block can accept a command.
- i_cmd_op  input  2  opcode: 0 BCAST, 1 SHIFT, 2 ROT, 3 DUMP.
- i_data  input  WIDTH  operand for BCAST and SHIFT.
- o_bank  output  WIDTH x [DEPTH-1:0] unpacked  current bank contents.
- o_stream_valid  output  1  stream word present.
- i_stream_ready  input  1  downstream accepts the stream word.
- o_stream_data  output  WIDTH  stream word.
- o_stream_last  output  1  marks the final stream word.
- o_busy  output  1  high while the FSM is in STREAM.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - Reset values: bank entries all 0; state IDLE; idx 0; o_stream_valid 0; o_stream_last 0; o_busy 0; o_stream_data 0.
  - o_cmd_ready = (state==IDLE) && !i_rst, so it is 0 during any reset cycle.
- A command is accepted when i_cmd_valid && o_cmd_ready. Updates are visible on o_bank the cycle after acceptance (1-cycle latency).
- BCAST: every entry k takes i_data (replication to the full unpacked array).
- SHIFT: bank[0] takes i_data; bank[k] takes bank[k-1] for k = 1..DEPTH-1; bank[DEPTH-1] is discarded.
- ROT: bank[0] takes bank[DEPTH-1]; bank[k] takes bank[k-1]. Rotating DEPTH times restores the original contents.
- DUMP: go to STREAM with idx = 0. Bank contents are unchanged.
- FSM:
  - IDLE: ready=1. DUMP leads to STREAM; all other ops stay in IDLE.
  - STREAM:
    - ready=0 and busy=1. The bank is frozen because no commands are accepted.
    - o_stream_valid=1, o_stream_data=bank[idx], o_stream_last=(idx==DEPTH-1).
    - On valid && i_stream_ready: if last, go to IDLE and set idx=0; otherwise idx+1.
- Stream stability: while valid && !ready, data and last are held stable. There is no combinational path from i_stream_ready to o_stream_valid.
- idx width is $clog2(DEPTH). No wrap beyond DEPTH-1.
- Boundary conditions:
  - i_cmd_valid high during STREAM: ignored and not accepted; the source must hold it.
  - Stream handshake and a new command in the same cycle: impossible by construction, since ready=0 in STREAM.
  - The cycle after the last beat: IDLE, ready=1.
  - Reset mid-STREAM: abort with no further beats; the bank clears to 0; back in IDLE one cycle after reset deasserts.
  - Reset and accepted command in the same cycle: reset wins (ready is already 0).
  - Illegal parameter values: elaboration-time error via $error in a generate check.

Optional Feature:
- Macro: SVI_BANK_STREAM_PARITY_EN.
- Defined: adds port o_stream_parity output 1 = ^o_stream_data (even parity). It is combinational from the registered data, valid only when o_stream_valid is high, and 0 in reset and IDLE.
- Undefined: the port is absent and there is no parity logic.
- All other behaviour is identical in both builds.

Decomposition:
- Package svi_bank_pkg:
  - op_e enum logic [1:0] {OP_BCAST, OP_SHIFT, OP_ROT, OP_DUMP};
  - state_e enum {ST_IDLE, ST_STREAM}.
- Sub-module: interface svi_bank_if #(DEPTH, WIDTH).
  - Holds the storage logic [WIDTH-1:0] bank [DEPTH-1:0] and the clocked update from op/data/enable inputs.
  - The top contains the FSM and the stream counter, and drives o_bank = u_if.bank.

Test Plan:
- Reset then BCAST, DEPTH=8, WIDTH=4, i_data=4'hA -> next cycle all o_bank entries = 4'hA; o_cmd_ready=1.
- Reset, then SHIFT 1,2,3 on consecutive cycles -> o_bank[0]=3, [1]=2, [2]=1, [3..7]=0; then ROT once -> [0]=0 (old [7]), [1]=3, [3]=1.
- Load 0..7 via SHIFT, DUMP with i_stream_ready=1 -> 8 beats with data 7,6,...,0, last on beat 8 only; o_cmd_ready=0 throughout; IDLE the next cycle.
- DUMP with i_stream_ready toggling 1,0,0,1 -> data and last held while stalled; exactly DEPTH beats; i_cmd_valid asserted during STREAM is not accepted and the bank is unchanged.
- Reset asserted on beat 3 of DUMP -> next cycle o_stream_valid=0, o_busy=0, o_bank all 0; ready=1 after reset drops.
- SVI_BANK_STREAM_PARITY_EN defined, WIDTH=4, BCAST 4'b0111 then DUMP -> o_stream_parity=1 on every beat; 0 while idle.

Source files
------------

// File: rtl/svi_bank_pkg.sv
// Shared types for the unpacked register bank: command opcodes and FSM states.
package svi_bank_pkg;

  typedef enum logic [1:0] {
    OP_BCAST = 2'd0,
    OP_SHIFT = 2'd1,
    OP_ROT   = 2'd2,
    OP_DUMP  = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/svi_bank_if.sv
// Interface that owns the DEPTH x WIDTH unpacked bank storage and applies
// broadcast / shift / rotate updates when the enclosing block enables it.
interface svi_bank_if
  import svi_bank_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 1
) (
  input logic clk,
  input logic rst
);

  logic             en;
  op_e              op;
  logic [WIDTH-1:0] data;

  logic [WIDTH-1:0] bank   [DEPTH-1:0];
  logic [WIDTH-1:0] bank_d [DEPTH-1:0];

  // Next bank contents: hold by default, rewrite the whole array on an enabled op.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      bank_d[k] = bank[k];
    end
    if (en) begin
      case (op)
        OP_BCAST: begin
          for (int k = 0; k < DEPTH; k++) begin
            bank_d[k] = data;
          end
        end
        OP_SHIFT: begin
          bank_d[0] = data;
          for (int k = 1; k < DEPTH; k++) begin
            bank_d[k] = bank[k-1];
          end
        end
        OP_ROT: begin
          bank_d[0] = bank[DEPTH-1];
          for (int k = 1; k < DEPTH; k++) begin
            bank_d[k] = bank[k-1];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Bank storage register; synchronous reset clears every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        bank[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        bank[k] <= bank_d[k];
      end
    end
  end

endinterface

// File: rtl/svi_unpacked_bank.sv
// Unpacked register bank with a valid/ready command port and a serial dump
// stream. Optional even-parity output on the stream is enabled by defining
// SVI_BANK_STREAM_PARITY_EN.
module svi_unpacked_bank
  import svi_bank_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_bank [DEPTH-1:0],
  output logic             o_stream_valid,
  input  logic             i_stream_ready,
  output logic [WIDTH-1:0] o_stream_data,
  output logic             o_stream_last,
  output logic             o_busy
`ifdef SVI_BANK_STREAM_PARITY_EN
  ,
  output logic             o_stream_parity
`endif
);

  localparam int               IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  generate
    if (DEPTH < 2 || DEPTH > 256 || WIDTH < 1 || WIDTH > 64) begin : g_param_check
      $error("svi_unpacked_bank: DEPTH must be 2..256 and WIDTH 1..64");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cmd_fire;
  logic             streaming;

  svi_bank_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_if (
    .clk (i_clk),
    .rst (i_rst)
  );

  assign u_if.en   = cmd_fire;
  assign u_if.op   = op_e'(i_cmd_op);
  assign u_if.data = i_data;
  assign o_bank    = u_if.bank;

  // Handshake decode, stream outputs from registered state, and next-state logic.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    streaming      = (state_q == ST_STREAM);
    o_cmd_ready    = (state_q == ST_IDLE) && !i_rst;
    cmd_fire       = i_cmd_valid && o_cmd_ready;
    o_busy         = streaming;
    o_stream_valid = streaming && !i_rst;
    o_stream_data  = streaming ? u_if.bank[idx_q] : '0;
    o_stream_last  = streaming && (idx_q == IDX_LAST);

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire && (op_e'(i_cmd_op) == OP_DUMP)) begin
          state_d = ST_STREAM;
          idx_d   = '0;
        end
      end
      ST_STREAM: begin
        if (o_stream_valid && i_stream_ready) begin
          if (o_stream_last) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // FSM state and stream index registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

`ifdef SVI_BANK_STREAM_PARITY_EN
  assign o_stream_parity = o_stream_valid & (^o_stream_data);
`endif

endmodule

// File: tb/tb_svi_unpacked_bank.sv
// Self-checking bench for svi_unpacked_bank with DEPTH=8, WIDTH=4.
module tb_svi_unpacked_bank;

  localparam int DEPTH = 8;
  localparam int WIDTH = 4;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_cmd_valid = 1'b0;
  logic             o_cmd_ready;
  logic [1:0]       i_cmd_op = 2'd0;
  logic [WIDTH-1:0] i_data = '0;
  logic [WIDTH-1:0] o_bank [DEPTH-1:0];
  logic             o_stream_valid;
  logic             i_stream_ready = 1'b0;
  logic [WIDTH-1:0] o_stream_data;
  logic             o_stream_last;
  logic             o_busy;
`ifdef SVI_BANK_STREAM_PARITY_EN
  logic             o_stream_parity;
`endif

  int passCount = 0;
  int checkCount = 0;

  svi_unpacked_bank #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_cmd_valid    (i_cmd_valid),
    .o_cmd_ready    (o_cmd_ready),
    .i_cmd_op       (i_cmd_op),
    .i_data         (i_data),
    .o_bank         (o_bank),
    .o_stream_valid (o_stream_valid),
    .i_stream_ready (i_stream_ready),
    .o_stream_data  (o_stream_data),
    .o_stream_last  (o_stream_last),
    .o_busy         (o_busy)
`ifdef SVI_BANK_STREAM_PARITY_EN
    ,
    .o_stream_parity(o_stream_parity)
`endif
  );

  // Free-running clock, period 10.
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [1:0]  op;
    logic [3:0]  data;
    logic        expReady;
    logic [31:0] expBank;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] packBank();
    logic [31:0] r;
    for (int k = 0; k < DEPTH; k++) r[4*k +: 4] = o_bank[k];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic rst, input logic valid, input logic [1:0] op,
                               input logic [3:0] data, input logic sready);
    i_rst          = rst;
    i_cmd_valid    = valid;
    i_cmd_op       = op;
    i_data         = data;
    i_stream_ready = sready;
  endtask

  task automatic addVec(input logic rst, input logic valid, input logic [1:0] op,
                        input logic [3:0] data, input logic expReady, input logic [31:0] expBank);
    vec_t v;
    v.rst = rst; v.valid = valid; v.op = op; v.data = data;
    v.expReady = expReady; v.expBank = expBank;
    vecs.push_back(v);
  endtask

  // Issue a DUMP from IDLE; returns once the block is in STREAM.
  task automatic startDump();
    applyStimulus(1'b0, 1'b1, 2'd3, 4'h0, 1'b0);
    @(negedge i_clk);
    applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
  endtask

  initial begin
    logic [3:0] expData [DEPTH];
    logic [3:0] prevData;
    logic       prevStall;
    int         beats;
    int         cyc;
    logic       pattern [4];

    // ckeck ops: 0 BCAST, 1 SHIFT, 2 ROT, 3 DUMP
    addVec(1, 0, 0, 4'h0, 0, 32'h0000_0000);
    addVec(0, 1, 0, 4'hA, 1, 32'hAAAA_AAAA);
    addVec(1, 1, 0, 4'hF, 0, 32'h0000_0000);
    addVec(0, 1, 1, 4'h1, 1, 32'h0000_0001);
    addVec(0, 1, 1, 4'h2, 1, 32'h0000_0012);
    addVec(0, 1, 1, 4'h3, 1, 32'h0000_0123);
    addVec(0, 1, 2, 4'h0, 1, 32'h0000_1230);
    addVec(0, 0, 0, 4'hF, 1, 32'h0000_1230);
    addVec(0, 1, 2, 4'h0, 1, 32'h0001_2300);
    addVec(0, 1, 2, 4'h0, 1, 32'h0012_3000);
    addVec(0, 1, 2, 4'h0, 1, 32'h0123_0000);
    addVec(0, 1, 2, 4'h0, 1, 32'h1230_0000);
    addVec(0, 1, 2, 4'h0, 1, 32'h2300_0001);
    addVec(0, 1, 2, 4'h0, 1, 32'h3000_0012);
    addVec(0, 1, 2, 4'h0, 1, 32'h0000_0123);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] b;
      b = 32'h0000_0123;
      for (int j = 0; j <= i; j++) b = {b[27:0], 4'(j)};
      addVec(0, 1, 1, 4'(i), 1, b);
    end

    // Table-driven command phase.
    @(negedge i_clk);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].op, vecs[i].data, 1'b0);
      @(negedge i_clk);
      checkOutput($sformatf("vec%0d_bank", i), packBank(), vecs[i].expBank);
      checkOutput($sformatf("vec%0d_ready", i), {31'd0, o_cmd_ready}, {31'd0, vecs[i].expReady});
      checkOutput($sformatf("vec%0d_idle", i), {30'd0, o_busy, o_stream_valid}, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
    @(negedge i_clk);
    checkOutput("loaded_bank", packBank(), 32'h0123_4567);

    // Full-speed DUMP: data 7..0, last only on the final beat.
    startDump();
    i_stream_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput($sformatf("dump_valid%0d", i), {31'd0, o_stream_valid}, 32'd1);
      checkOutput($sformatf("dump_data%0d", i), {28'd0, o_stream_data}, 32'(7 - i));
      checkOutput($sformatf("dump_last%0d", i), {31'd0, o_stream_last}, {31'd0, i == DEPTH - 1});
      checkOutput($sformatf("dump_ready%0d", i), {30'd0, o_cmd_ready, o_busy}, 32'd1);
      @(negedge i_clk);
    end
    i_stream_ready = 1'b0;
    checkOutput("dump_end_ready", {31'd0, o_cmd_ready}, 32'd1);
    checkOutput("dump_end_valid", {30'd0, o_stream_valid, o_busy}, 32'd0);

    // Stalled DUMP with a command held pending during STREAM.
    for (int k = 0; k < DEPTH; k++) expData[k] = 4'(7 - k);
    pattern[0] = 1'b1; pattern[1] = 1'b0; pattern[2] = 1'b0; pattern[3] = 1'b1;
    startDump();
    i_cmd_valid = 1'b1; i_cmd_op = 2'd0; i_data = 4'hF;
    beats = 0; cyc = 0; prevStall = 1'b0; prevData = 4'h0;
    while (beats < DEPTH && cyc < 60) begin
      i_stream_ready = pattern[cyc % 4];
      if (o_stream_valid) begin
        checkOutput($sformatf("stall_data_b%0d", beats), {28'd0, o_stream_data}, {28'd0, expData[beats]});
        checkOutput($sformatf("stall_last_b%0d", beats), {31'd0, o_stream_last}, {31'd0, beats == DEPTH - 1});
        if (prevStall) checkOutput($sformatf("stall_hold_c%0d", cyc), {28'd0, o_stream_data}, {28'd0, prevData});
        prevStall = !i_stream_ready;
        prevData  = o_stream_data;
        if (i_stream_ready) begin
          beats++;
          if (beats == DEPTH) i_cmd_valid = 1'b0;
        end
      end else begin
        checkOutput("stall_valid_drop", {31'd0, o_stream_valid}, 32'd1);
      end
      cyc++;
      @(negedge i_clk);
    end
    checkOutput("stall_beats", 32'(beats), 32'(DEPTH));
    i_cmd_valid = 1'b0; i_stream_ready = 1'b0;
    checkOutput("stall_end_ready", {31'd0, o_cmd_ready}, 32'd1);
    checkOutput("stall_bank_unchanged", packBank(), 32'h0123_4567);

    // Reset asserted on beat 3 of a DUMP.
    startDump();
    i_stream_ready = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge i_clk);
    checkOutput("rst_beat3_data", {28'd0, o_stream_data}, 32'd4);
    i_rst = 1'b1;
    @(negedge i_clk);
    checkOutput("rst_mid_valid", {31'd0, o_stream_valid}, 32'd0);
    checkOutput("rst_mid_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("rst_mid_bank", packBank(), 32'd0);
    checkOutput("rst_mid_ready", {31'd0, o_cmd_ready}, 32'd0);
    i_rst = 1'b0; i_stream_ready = 1'b0;
    @(negedge i_clk);
    checkOutput("rst_after_ready", {31'd0, o_cmd_ready}, 32'd1);
    checkOutput("rst_after_valid", {31'd0, o_stream_valid}, 32'd0);

`ifdef SVI_BANK_STREAM_PARITY_EN
    // Even parity of 4'b0111 is 1 on every beat, 0 when idle.
    checkOutput("par_idle", {31'd0, o_stream_parity}, 32'd0);
    applyStimulus(1'b0, 1'b1, 2'd0, 4'b0111, 1'b0);
    @(negedge i_clk);
    startDump();
    i_stream_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput($sformatf("par_beat%0d", i), {31'd0, o_stream_parity}, 32'd1);
      @(negedge i_clk);
    end
    i_stream_ready = 1'b0;
    checkOutput("par_after", {31'd0, o_stream_parity}, 32'd0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
